// File: rtl/mac_accumulator_4bit_pkg.sv
// rtl/mac_accumulator_4bit_pkg.sv - shared state encodings, defaults and clog2 helper for the MAC block
package mac_accumulator_4bit_pkg;

    typedef enum logic [1:0] {
        MAC_ST_ACCUM = 2'd0,
        MAC_ST_FLUSH = 2'd1,
        MAC_ST_DONE  = 2'd2
    } mac_state_e;

    localparam int MAC_TERMS_DEFAULT = 4;
    localparam int MAC_ACC_W_DEFAULT = 10;

    function automatic int mac_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ArrayMultiplier4Bit.sv
// rtl/ArrayMultiplier4Bit.sv - combinational 4x4 unsigned array multiplier
module ArrayMultiplier4Bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Each row is the multiplicand gated by one multiplier bit, shifted into place.
    always_comb begin
        p = 8'd0;
        for (int i = 0; i < 4; i++) begin
            p = p + ({4'd0, (a & {4{b[i]}})} << i);
        end
    end

endmodule

// File: rtl/mac_accumulator_4bit.sv
// rtl/mac_accumulator_4bit.sv - multiply-accumulate stage summing TERMS products; MAC_SATURATE_EN enables clamping
module mac_accumulator_4bit
    import mac_accumulator_4bit_pkg::*;
#(
    parameter int TERMS = MAC_TERMS_DEFAULT,
    parameter int ACC_W = MAC_ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat
);

    localparam int CNT_W = (mac_clog2(TERMS) < 1) ? 1 : mac_clog2(TERMS);

    mac_state_e       state_q;
    logic [CNT_W-1:0] term_cnt_q;
    logic [3:0]       op_a_q;
    logic [3:0]       op_b_q;
    logic             s1_valid_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] out_data_q;
    logic             out_valid_q;
    logic [7:0]       prod;
    logic             in_xfer;

    assign in_ready  = (state_q == MAC_ST_ACCUM);
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    ArrayMultiplier4Bit u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (prod)
    );

`ifdef MAC_SATURATE_EN
    logic [ACC_W:0] acc_sum;
    logic           sat_q;
    logic           sat_d;
    logic           out_sat_q;

    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(prod);
    assign acc_d   = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign sat_d   = sat_q | acc_sum[ACC_W];
    assign out_sat = out_sat_q;
`else
    assign acc_d   = acc_q + ACC_W'(prod);
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MAC_ST_ACCUM;
            term_cnt_q  <= '0;
            op_a_q      <= 4'd0;
            op_b_q      <= 4'd0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef MAC_SATURATE_EN
            sat_q       <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q <= in_xfer;
            if (in_xfer) begin
                op_a_q <= a;
                op_b_q <= b;
            end
            if (s1_valid_q) begin
                acc_q <= acc_d;
`ifdef MAC_SATURATE_EN
                sat_q <= sat_d;
`endif
            end

            case (state_q)
                MAC_ST_ACCUM: begin
                    if (in_xfer) begin
                        if (term_cnt_q == CNT_W'(TERMS - 1)) begin
                            term_cnt_q <= '0;
                            state_q    <= MAC_ST_FLUSH;
                        end else begin
                            term_cnt_q <= term_cnt_q + CNT_W'(1);
                        end
                    end
                end
                // Stay until the last product has landed in acc, then publish it.
                MAC_ST_FLUSH: begin
                    if (!s1_valid_q) begin
                        out_data_q  <= acc_q;
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
`ifdef MAC_SATURATE_EN
                        out_sat_q   <= sat_q;
                        sat_q       <= 1'b0;
`endif
                        state_q     <= MAC_ST_DONE;
                    end
                end
                MAC_ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= MAC_ST_ACCUM;
                    end
                end
                default: begin
                    state_q    <= MAC_ST_ACCUM;
                    term_cnt_q <= '0;
                    acc_q      <= '0;
`ifdef MAC_SATURATE_EN
                    sat_q      <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator_4bit.sv
// tb/tb_mac_accumulator_4bit.sv - directed self-checking bench for mac_accumulator_4bit (ACC_W=10 and ACC_W=9)
module tb_mac_accumulator_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_sat;

    logic       in_ready9;
    logic       out_valid9;
    logic [8:0] out_data9;
    logic       out_sat9;

    int checks;
    int errors;

    mac_accumulator_4bit #(.TERMS(4), .ACC_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    mac_accumulator_4bit #(.TERMS(4), .ACC_W(9)) dut9 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready9),
        .a         (a),
        .b         (b),
        .out_valid (out_valid9),
        .out_ready (out_ready),
        .out_data  (out_data9),
        .out_sat   (out_sat9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y);
        in_valid = 1'b1;
        a = x;
        b = y;
        for (int k = 0; k < 20 && !in_ready; k++) step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output bit found);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (out_valid === 1'b1) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL result_timeout: out_valid=%b required 1 within 20 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 10'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%0d sat=%b required 0 0 0", out_valid, out_data, out_sat);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_full_scale();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(4'd15, 4'd15);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_t0: valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_t1: valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd900 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL full_t2: valid=%b data=%0d sat=%b required 1 900 0", out_valid, out_data, out_sat);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_t3: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        send(4'd3, 4'd5);
        step();
        step();
        send(4'd0, 4'd9);
        step();
        send(4'd7, 4'd7);
        send(4'd1, 4'd1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bubble_flush%0d: in_ready=%b valid=%b required 0 0", k, in_ready, out_valid);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd65 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bubble_result: valid=%b data=%0d in_ready=%b required 1 65 0", out_valid, out_data, in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_reopen: in_ready=%b valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd2, 4'd3);
        wait_result(found);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'd24 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b data=%0d in_ready=%b required 1 24 0", k, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) send(4'd2, 4'd2);
        wait_result(found);
        checks++;
        if (out_data !== 10'd16) begin
            errors++;
            $display("FAIL second_sum: data=%0d required 16", out_data);
        end
        step();
    endtask

    task automatic test_mid_reset();
        bit found;
        out_ready = 1'b1;
        send(4'd5, 4'd5);
        send(4'd5, 4'd5);
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 10'd0 || out_sat !== 1'b0 ||
            out_valid9 !== 1'b0 || out_data9 !== 9'd0 || out_sat9 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b data=%0d sat=%b data9=%0d required 0 0 0 0",
                     out_valid, out_data, out_sat, out_data9);
        end
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
        wait_result(found);
        checks++;
        if (out_data !== 10'd4 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL midreset_sum: data=%0d sat=%b required 4 0", out_data, out_sat);
        end
        step();
    endtask

    task automatic test_saturate();
        bit found;
        logic [8:0] exp_data9;
        logic       exp_sat9;
`ifdef MAC_SATURATE_EN
        exp_data9 = 9'd511;
        exp_sat9  = 1'b1;
`else
        exp_data9 = 9'd388;
        exp_sat9  = 1'b0;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(4'd15, 4'd15);
        wait_result(found);
        checks++;
        if (out_data9 !== exp_data9 || out_sat9 !== exp_sat9) begin
            errors++;
            $display("FAIL acc9_overflow: data=%0d sat=%b required %0d %b", out_data9, out_sat9, exp_data9, exp_sat9);
        end
        checks++;
        if (out_data !== 10'd900 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL acc10_no_overflow: data=%0d sat=%b required 900 0", out_data, out_sat);
        end
        step();
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1);
        wait_result(found);
        checks++;
        if (out_data9 !== 9'd4 || out_sat9 !== 1'b0) begin
            errors++;
            $display("FAIL acc9_clean: data=%0d sat=%b required 4 0", out_data9, out_sat9);
        end
        step();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        out_ready = 1'b1;
        test_reset();
        test_full_scale();
        test_bubbles();
        test_backpressure();
        test_mid_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
